// File: rtl/audio_i2s_tx.sv
// I2S transmitter: takes 16-bit stereo pairs over valid/ready and shifts them out MSB-first.
// BCLK and LRCLK come from an integer divider. An empty holding register at a frame boundary repeats the last frame.
module audio_i2s_tx #(
    parameter int BCLK_DIV    = 4,
    parameter int SAMPLE_BITS = 16
) (
    input  logic                   I_clock,
    input  logic                   I_reset,
    input  logic [SAMPLE_BITS-1:0] I_left,
    input  logic [SAMPLE_BITS-1:0] I_right,
    input  logic                   I_valid,
    output logic                   O_ready,
    output logic                   O_bclk,
    output logic                   O_lrclk,
    output logic                   O_sdata,
    output logic                   O_underrun
);
    localparam int W  = SAMPLE_BITS;
    localparam int KW = $clog2(2 * W);
    localparam int CW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;

    localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);
    localparam logic [KW-1:0] K_LAST   = KW'(2 * W - 1);
    localparam logic [KW-1:0] K_W      = KW'(W);
    localparam logic [KW-1:0] K_LR_LO  = KW'(W - 1);
    localparam logic [KW-1:0] K_LR_HI  = KW'(2 * W - 2);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          bclk_q, bclk_d;
    logic [KW-1:0] k_q, k_d;
    logic [W-1:0]  frame_l_q, frame_l_d, frame_r_q, frame_r_d;
    logic [W-1:0]  hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic          hold_full_q, hold_full_d;
    logic          ready_q, ready_d;
    logic          lrclk_q, lrclk_d;
    logic          sdata_q, sdata_d;
    logic          underrun_q, underrun_d;
    logic          fall_s, accept_s;

    // Select bit i of v with a loop so the index width never has to match the vector width.
    function automatic logic pick_bit(input logic [W-1:0] v, input logic [KW-1:0] i);
        logic r;
        r = 1'b0;
        for (int b = 0; b < W; b++) begin
            if (KW'(b) == i) begin
                r = v[b];
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

    // Divider, slot counter, handshake and frame load.
    always_comb begin
        cnt_d       = cnt_q;
        bclk_d      = bclk_q;
        k_d         = k_q;
        frame_l_d   = frame_l_q;
        frame_r_d   = frame_r_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        hold_full_d = hold_full_q;
        lrclk_d     = lrclk_q;
        sdata_d     = sdata_q;
        underrun_d  = 1'b0;

        fall_s   = (cnt_q == CNT_LAST) && bclk_q;
        accept_s = I_valid && ready_q;

        if (cnt_q == CNT_LAST) begin
            cnt_d  = {CW{1'b0}};
            bclk_d = ~bclk_q;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end

        if (accept_s) begin
            hold_l_d    = I_left;
            hold_r_d    = I_right;
            hold_full_d = 1'b1;
        end else begin
            hold_l_d    = hold_l_q;
        end

        if (fall_s) begin
            if (k_q == K_LAST) begin
                k_d = {KW{1'b0}};
                // The load only ever sees the holding register as it was before this edge: no bypass.
                if (hold_full_q) begin
                    frame_l_d   = hold_l_q;
                    frame_r_d   = hold_r_q;
                    hold_full_d = 1'b0;
                end else begin
                    underrun_d  = 1'b1;
                end
            end else begin
                k_d = k_q + KW'(1);
            end
            lrclk_d = (k_d >= K_LR_LO) && (k_d <= K_LR_HI);
            if (k_d < K_W) begin
                sdata_d = pick_bit(frame_l_d, K_LR_LO - k_d);
            end else begin
                sdata_d = pick_bit(frame_r_d, K_LAST - k_d);
            end
        end else begin
            k_d = k_q;
        end

        ready_d = ~hold_full_d;
    end

    // State registers.
    always_ff @(posedge I_clock or negedge I_reset) begin
        if (!I_reset) begin
            cnt_q       <= {CW{1'b0}};
            bclk_q      <= 1'b0;
            k_q         <= K_LAST;
            frame_l_q   <= {W{1'b0}};
            frame_r_q   <= {W{1'b0}};
            hold_l_q    <= {W{1'b0}};
            hold_r_q    <= {W{1'b0}};
            hold_full_q <= 1'b0;
            ready_q     <= 1'b1;
            lrclk_q     <= 1'b0;
            sdata_q     <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            bclk_q      <= bclk_d;
            k_q         <= k_d;
            frame_l_q   <= frame_l_d;
            frame_r_q   <= frame_r_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            hold_full_q <= hold_full_d;
            ready_q     <= ready_d;
            lrclk_q     <= lrclk_d;
            sdata_q     <= sdata_d;
            underrun_q  <= underrun_d;
        end
    end

    assign O_ready    = ready_q;
    assign O_bclk     = bclk_q;
    assign O_lrclk    = lrclk_q;
    assign O_sdata    = sdata_q;
    assign O_underrun = underrun_q;

endmodule

// File: tb/tb_audio_i2s_tx.sv
// Scoreboard bench for audio_i2s_tx (BCLK_DIV = 2, W = 16): the stimulus pushes the expected frames,
// and an I2S receiver model collects the bits on BCLK rising edges, then pops and compares each frame.
module tb_audio_i2s_tx;
    localparam int DIV   = 2;
    localparam int FRAME = 128;

    logic        clk, rst_n, valid;
    logic [15:0] left, right;
    logic        ready, bclk, lrclk, sdata, underrun;

    typedef struct {
        logic [15:0] l;
        logic [15:0] r;
        logic        ur;
    } exp_t;
    exp_t sb_q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int since_rel;

    audio_i2s_tx #(.BCLK_DIV(DIV), .SAMPLE_BITS(16)) dut (
        .I_clock(clk), .I_reset(rst_n), .I_left(left), .I_right(right), .I_valid(valid),
        .O_ready(ready), .O_bclk(bclk), .O_lrclk(lrclk), .O_sdata(sdata), .O_underrun(underrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Clocks since reset release; the first frame boundary is the 4th rising edge, then every 128.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) since_rel <= 0;
        else        since_rel <= since_rel + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [15:0] l, input logic [15:0] r, input logic ur);
        exp_t e;
        e.l = l; e.r = r; e.ur = ur;
        sb_q.push_back(e);
    endtask

    task automatic wait_phase(input int ph);
        do @(negedge clk); while ((since_rel % FRAME) != ph);
    endtask

    task automatic send(input logic [15:0] l, input logic [15:0] r, input logic keep);
        left = l; right = r; valid = 1'b1;
        for (int t = 0; t < 400 && !ready; t++) @(negedge clk);
        check("send_ready", 32'(ready), 32'd1);
        @(negedge clk);
        valid = keep;
    endtask

    // Receiver model and scoreboard consumer.
    initial begin : monitor
        logic        prev_bclk, active, fur, lr_ok, exp_lr;
        logic [4:0]  mk;
        logic [15:0] fl, fr;
        int          gap, last_rise;
        exp_t        e;
        prev_bclk = 1'b0; active = 1'b0; mk = 5'd31; fl = 16'd0; fr = 16'd0;
        fur = 1'b0; lr_ok = 1'b1; gap = 0; last_rise = -1;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_bclk = 1'b0; active = 1'b0; mk = 5'd31; last_rise = -1; gap = 0;
            end else begin
                gap++;
                if (prev_bclk && !bclk) begin
                    mk = mk + 5'd1;
                    if (mk == 5'd0) begin
                        active = 1'b1; fur = underrun; fl = 16'd0; fr = 16'd0; lr_ok = 1'b1;
                    end else begin
                        check("underrun_off_boundary", 32'(underrun), 32'd0);
                    end
                end else begin
                    check("underrun_off_boundary", 32'(underrun), 32'd0);
                end
                if (!prev_bclk && bclk) begin
                    if (last_rise >= 0) check("bclk_period", 32'(gap), 32'(2 * DIV));
                    last_rise = 1; gap = 0;
                    if (active) begin
                        if (mk < 5'd16) fl[4'd15 - mk[3:0]] = sdata;
                        else            fr[4'd15 - mk[3:0]] = sdata;
                        exp_lr = (mk >= 5'd15) && (mk <= 5'd30);
                        if (lrclk !== exp_lr) lr_ok = 1'b0;
                        if (mk == 5'd31) begin
                            if (sb_q.size() == 0) begin
                                check("sb_nonempty", 32'd0, 32'd1);
                            end else begin
                                e = sb_q.pop_front();
                                check("frame_left", 32'(fl), 32'(e.l));
                                check("frame_right", 32'(fr), 32'(e.r));
                                check("frame_underrun", 32'(fur), 32'(e.ur));
                                check("frame_lrclk", 32'(lr_ok), 32'd1);
                            end
                        end
                    end
                end
                prev_bclk = bclk;
            end
        end
    end

    initial begin : watchdog
        repeat (6000) @(posedge clk);
        $display("FAIL watchdog: cycle budget exhausted, %0d frames still expected", sb_q.size());
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        rst_n = 1'b0; valid = 1'b0; left = 16'd0; right = 16'd0;
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_bclk", 32'(bclk), 32'd0);
        check("rst_lrclk", 32'(lrclk), 32'd0);
        check("rst_sdata", 32'(sdata), 32'd0);
        check("rst_underrun", 32'(underrun), 32'd0);
        rst_n = 1'b1;

        // Idle frames: all-zero data, underrun every frame.
        push(16'h0000, 16'h0000, 1'b1);
        push(16'h0000, 16'h0000, 1'b1);
        wait_phase(4);
        wait_phase(4);

        // Single pair; ready stays low until the next boundary, then recovers.
        push(16'hA5F0, 16'h0F0F, 1'b0);
        send(16'hA5F0, 16'h0F0F, 1'b0);
        check("ready_after_accept", 32'(ready), 32'd0);
        wait_phase(3);
        check("ready_before_boundary", 32'(ready), 32'd0);
        @(negedge clk);
        check("ready_after_boundary", 32'(ready), 32'd1);

        // Streaming producer: n, ~n in consecutive frames with no underrun.
        for (int i = 1; i <= 4; i++) push(16'(i), ~16'(i), 1'b0);
        for (int i = 1; i <= 4; i++) send(16'(i), ~16'(i), (i < 4) ? 1'b1 : 1'b0);

        // One pair, then starve: the frame repeats with an underrun each time.
        push(16'h8000, 16'h7FFF, 1'b0);
        push(16'h8000, 16'h7FFF, 1'b1);
        push(16'h8000, 16'h7FFF, 1'b1);
        send(16'h8000, 16'h7FFF, 1'b0);
        wait_phase(4);
        wait_phase(4);
        wait_phase(4);

        // Accept in the very boundary clock: old frame repeats, new pair follows.
        push(16'h8000, 16'h7FFF, 1'b1);
        push(16'h1234, 16'hABCD, 1'b0);
        wait_phase(3);
        left = 16'h1234; right = 16'hABCD; valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
        check("ready_boundary_accept", 32'(ready), 32'd0);
        wait_phase(4);
        wait_phase(4);

        // Fill holding, then reset mid-frame around k = 20; the pending pair must be lost.
        send(16'h5555, 16'hAAAA, 1'b0);
        check("ready_before_reset", 32'(ready), 32'd0);
        repeat (80) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_bclk", 32'(bclk), 32'd0);
        check("midrst_lrclk", 32'(lrclk), 32'd0);
        check("midrst_sdata", 32'(sdata), 32'd0);
        check("midrst_underrun", 32'(underrun), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push(16'h0000, 16'h0000, 1'b1);
        push(16'h0000, 16'h0000, 1'b1);

        for (int t = 0; t < 400 && sb_q.size() != 0; t++) @(negedge clk);
        check("sb_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
